fb_draw_ctrl: RTL and testbench

- Command-driven sequencer that owns the framebuffer write port (port B) and turns drawing commands into one pixel write per cycle.
- Supported commands: single pixel, clipped filled rectangle, full-screen clear.
- Sits between the CPU/rasterizer command source and the framebuffer. The VGA read port (port A) is untouched.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_addr_gen.sv | 55 +++++
 rtl/fb_draw_ctrl.sv | 134 +++++++++++++
 tb/tb_fb_draw_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, command opcodes and draw FSM states.
// Row bases are built by shift-add from the width constant, so no multiplier is inferred.
package fb_pkg;
    localparam int FB_W       = 214;
    localparam int FB_H       = 160;
    localparam int FB_WORDS   = FB_W * FB_H;
    localparam int FB_A_WIDTH = 16;
    localparam int FB_D_WIDTH = 3;

    localparam logic [7:0]            FB_X_MAX    = 8'(FB_W - 1);
    localparam logic [7:0]            FB_Y_MAX    = 8'(FB_H - 1);
    localparam logic [FB_A_WIDTH-1:0] FB_ROW_STEP = FB_A_WIDTH'(FB_W);

    typedef enum logic [1:0] {PLOT = 2'b00, FILL = 2'b01, CLEAR = 2'b10, RSVD = 2'b11} fb_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} fb_state_t;

    function automatic logic [FB_A_WIDTH-1:0] row_base(input logic [7:0] y);
        logic [FB_A_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < FB_A_WIDTH; i++) begin
            if (FB_ROW_STEP[i]) acc = acc + (FB_A_WIDTH'(y) << i);
        end
        return acc;
    endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// Row-major x/y walker over an already-clipped rectangle; addr is registered, valid the cycle after load.
// Advances only on step; no backpressure of its own, last flags the final pixel of the rectangle.
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [7:0]            x0,
    input  logic [7:0]            y0,
    input  logic [7:0]            x1,
    input  logic [7:0]            y1,
    output logic [FB_A_WIDTH-1:0] addr,
    output logic                  last
);
    logic [7:0]            r_x, r_y, r_x0, r_x1, r_y1;
    logic [FB_A_WIDTH-1:0] r_base, r_addr;
    logic                  w_row_end;

    assign w_row_end = (r_x == r_x1);
    assign last      = w_row_end && (r_y == r_y1);
    assign addr      = r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_x0   <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_base <= '0;
            r_addr <= '0;
        end else if (load) begin
            r_x    <= x0;
            r_y    <= y0;
            r_x0   <= x0;
            r_x1   <= x1;
            r_y1   <= y1;
            r_base <= row_base(y0);
            r_addr <= row_base(y0) + FB_A_WIDTH'(x0);
        end else if (step) begin
            if (w_row_end) begin
                // Wrap to the next row: base accumulates one row width, x restarts at x0.
                r_x    <= r_x0;
                r_y    <= r_y + 8'd1;
                r_base <= r_base + FB_ROW_STEP;
                r_addr <= r_base + FB_ROW_STEP + FB_A_WIDTH'(r_x0);
            end else begin
                r_x    <= r_x + 8'd1;
                r_addr <= r_addr + 16'd1;
            end
        end
    end
endmodule

// File: rtl/fb_draw_ctrl.sv
// Turns PLOT/FILL/CLEAR commands into one framebuffer port-B write per cycle, first write the cycle after accept.
// cmd_ready only in IDLE/DONE; commands offered while busy are dropped, not queued.
module fb_draw_ctrl
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [7:0]            cmd_x0,
    input  logic [7:0]            cmd_y0,
    input  logic [7:0]            cmd_x1,
    input  logic [7:0]            cmd_y1,
    input  logic [FB_D_WIDTH-1:0] cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic [FB_A_WIDTH-1:0] fb_addr,
    output logic                  fb_write_en,
    output logic [FB_D_WIDTH-1:0] fb_write_data
);
    fb_state_t             r_state;
    logic                  r_ready, r_busy, r_done, r_we;
    logic [FB_D_WIDTH-1:0] r_data;

    fb_op_t     w_op;
    logic [7:0] w_cx1, w_cy1, w_lx0, w_ly0, w_lx1, w_ly1;
    logic       w_nonempty, w_accept, w_load, w_step, w_last;

    assign w_op  = fb_op_t'(cmd_op);
    assign w_cx1 = (cmd_x1 > FB_X_MAX) ? FB_X_MAX : cmd_x1;
    assign w_cy1 = (cmd_y1 > FB_Y_MAX) ? FB_Y_MAX : cmd_y1;

    always_comb begin
        w_nonempty = 1'b0;
        w_lx0      = cmd_x0;
        w_ly0      = cmd_y0;
        w_lx1      = cmd_x0;
        w_ly1      = cmd_y0;
        case (w_op)
            PLOT: w_nonempty = (cmd_x0 <= FB_X_MAX) && (cmd_y0 <= FB_Y_MAX);
            FILL: begin
                w_nonempty = (cmd_x0 <= w_cx1) && (cmd_y0 <= w_cy1) &&
                             (cmd_x0 <= FB_X_MAX) && (cmd_y0 <= FB_Y_MAX);
                w_lx1 = w_cx1;
                w_ly1 = w_cy1;
            end
            CLEAR: begin
                w_nonempty = 1'b1;
                w_lx0      = 8'd0;
                w_ly0      = 8'd0;
                w_lx1      = FB_X_MAX;
                w_ly1      = FB_Y_MAX;
            end
            default: w_nonempty = 1'b0;
        endcase
    end

    assign w_accept = cmd_valid && r_ready;
    // Generator is loaded only for non-empty commands so fb_addr never leaves the framebuffer.
    assign w_load   = w_accept && w_nonempty;
    assign w_step   = (r_state == ST_WRITE) && !w_last;

    fb_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .x0    (w_lx0),
        .y0    (w_ly0),
        .x1    (w_lx1),
        .y1    (w_ly1),
        .addr  (fb_addr),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_data <= cmd_color;
                        if (w_nonempty) begin
                            r_state <= ST_WRITE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_we    <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fb_write_en   = r_we;
    assign fb_write_data = r_data;
endmodule

// File: tb/tb_fb_draw_ctrl.sv
// Directed plus random command bench; expected pixel streams come from a rectangle-clipping model.
module tb_fb_draw_ctrl;
    localparam int W = 214;
    localparam int H = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [2:0]  cmd_color = '0;
    logic        busy, done, fb_write_en;
    logic [15:0] fb_addr;
    logic [2:0]  fb_write_data;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    fb_draw_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x0        (cmd_x0),
        .cmd_y0        (cmd_y0),
        .cmd_x1        (cmd_x1),
        .cmd_y1        (cmd_y1),
        .cmd_color     (cmd_color),
        .busy          (busy),
        .done          (done),
        .fb_addr       (fb_addr),
        .fb_write_en   (fb_write_en),
        .fb_write_data (fb_write_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: list of addresses a command must write, in order.
    task automatic build(input int op, input int x0, input int y0, input int x1, input int y1);
        int cx1, cy1;
        exp_q.delete();
        cx1 = (x1 > W - 1) ? W - 1 : x1;
        cy1 = (y1 > H - 1) ? H - 1 : y1;
        case (op)
            0: if (x0 < W && y0 < H) exp_q.push_back(y0 * W + x0);
            1: for (int y = y0; y <= cy1; y++)
                   for (int x = x0; x <= cx1; x++) exp_q.push_back(y * W + x);
            2: for (int a = 0; a < W * H; a++) exp_q.push_back(a);
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_done", done, 0);
            chk("idle_we", fb_write_en, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    // Called at a negedge where cmd_ready is expected; returns at the negedge of the done cycle,
    // or at write abort_at after driving rst_n low.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] col,
                           input int abort_at);
        int n;
        build(int'(op), int'(x0), int'(y0), int'(x1), int'(y1));
        n = exp_q.size();
        chk("ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_x0 = x0; cmd_y0 = y0;
        cmd_x1 = x1; cmd_y1 = y1; cmd_color = col;
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            chk("write_en", fb_write_en, 1);
            chk("write_addr", fb_addr, exp_q[k-1]);
            chk("write_data", fb_write_data, col);
            chk("busy_writing", busy, 1);
            chk("ready_writing", cmd_ready, 0);
            chk("done_writing", done, 0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                cmd_valid = 1'b0;
                return;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom); cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom);
            cmd_x1 = 8'($urandom); cmd_y1 = 8'($urandom); cmd_color = 3'($urandom);
        end
        if (n > 0) @(negedge clk);
        cmd_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("ready_done", cmd_ready, 1);
        chk("we_done", fb_write_en, 0);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", fb_write_en, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_write_data, 0);
        rst_n = 1'b1;
        idle(2);

        run_cmd(2'd0, 8'd5, 8'd2, 8'd0, 8'd0, 3'd3, 0);
        idle(1);
        run_cmd(2'd1, 8'd10, 8'd20, 8'd12, 8'd21, 3'd5, 0);
        run_cmd(2'd1, 8'd210, 8'd158, 8'd255, 8'd255, 3'd1, 0);
        run_cmd(2'd1, 8'd50, 8'd0, 8'd40, 8'd5, 3'd2, 0);
        run_cmd(2'd3, 8'd1, 8'd1, 8'd9, 8'd9, 3'd6, 0);
        idle(1);
        run_cmd(2'd0, 8'd250, 8'd5, 8'd0, 8'd0, 3'd7, 0);
        run_cmd(2'd0, 8'd5, 8'd160, 8'd0, 8'd0, 3'd7, 0);
        run_cmd(2'd1, 8'd214, 8'd0, 8'd255, 8'd3, 3'd4, 0);
        run_cmd(2'd1, 8'd0, 8'd10, 8'd3, 8'd9, 3'd4, 0);
        run_cmd(2'd1, 8'd213, 8'd159, 8'd213, 8'd159, 3'd6, 0);
        run_cmd(2'd0, 8'd213, 8'd159, 8'd0, 8'd0, 3'd2, 0);
        idle(2);

        for (int r = 0; r < 40; r++) begin
            logic [1:0] rop;
            int ax0, ay0, ax1, ay1;
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'd2) rop = 2'd1;
            ax0 = $urandom_range(0, 220);
            ay0 = $urandom_range(0, 165);
            ax1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : ax0 + int'($urandom_range(0, 12));
            ay1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : ay0 + int'($urandom_range(0, 12));
            if (ax1 > 255) ax1 = 255;
            if (ay1 > 255) ay1 = 255;
            run_cmd(rop, 8'(ax0), 8'(ay0), 8'(ax1), 8'(ay1), 3'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end

        run_cmd(2'd2, 8'd33, 8'd44, 8'd1, 8'd1, 3'd0, 0);
        idle(1);

        run_cmd(2'd2, 8'd0, 8'd0, 8'd0, 8'd0, 3'd4, 100);
        @(negedge clk);
        chk("abort_we", fb_write_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_done", done, 0);
        chk("post_rst_we", fb_write_en, 0);
        run_cmd(2'd0, 8'd100, 8'd50, 8'd0, 8'd0, 3'd7, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
